// File: rtl/aes_pkg.sv
// Shared AES types, GF(2^8) helper and the MixColumns engine state encoding.
package aes_pkg;

    localparam int NUM_COLS = 4;
    localparam int COL_W    = 32;

    typedef logic [127:0] state_t;
    typedef logic [31:0]  col_t;
    typedef logic [7:0]   byte_t;

    // Reduction constant for x^8 + x^4 + x^3 + x + 1 once the x^8 term is shifted out.
    localparam byte_t AES_POLY = 8'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } eng_state_t;

    // Multiply by x in GF(2^8), result truncated to 8 bits.
    function automatic byte_t xtime(input byte_t b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/mix_col.sv
// Combinational MixColumns for one 32-bit column (row 0 = MSB byte).
// inv=1 selects InvMixColumns; the engine ties inv low when the inverse is not built,
// which lets synthesis drop the inverse coefficients entirely.
module mix_col
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
    input  logic        inv,
    output logic [31:0] col_out
);

    byte_t a  [4];
    byte_t x2 [4];
    byte_t x4 [4];
    byte_t x8 [4];

    // Split the column into bytes and build the doubling chain for each byte.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            a[r]  = col_in[31-8*r -: 8];
            x2[r] = xtime(a[r]);
            x4[r] = xtime(x2[r]);
            x8[r] = xtime(x4[r]);
        end
    end

    // Row r: forward uses {2,3,1,1}, inverse uses {0e,0b,0d,09} rotated by r.
    always_comb begin
        col_out = '0;
        for (int r = 0; r < 4; r++) begin
            if (inv) begin
                col_out[31-8*r -: 8] =
                    (x8[r]       ^ x4[r]       ^ x2[r])       ^  // 0e * a_r
                    (x8[(r+1)%4] ^ x2[(r+1)%4] ^ a[(r+1)%4])  ^  // 0b * a_(r+1)
                    (x8[(r+2)%4] ^ x4[(r+2)%4] ^ a[(r+2)%4])  ^  // 0d * a_(r+2)
                    (x8[(r+3)%4] ^ a[(r+3)%4]);                  // 09 * a_(r+3)
            end else begin
                col_out[31-8*r -: 8] =
                    x2[r] ^
                    (x2[(r+1)%4] ^ a[(r+1)%4]) ^
                    a[(r+2)%4] ^
                    a[(r+3)%4];
            end
        end
    end

endmodule

// File: rtl/mix_cols_engine.sv
// AES MixColumns engine: accepts a 128-bit state, mixes one column per clock through
// a single shared mix_col, then presents the result until downstream takes it.
// Optional build macro MIX_COLS_INVERSE_EN enables InvMixColumns selected by in_inv.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
// Upstream holds in_valid/in_state until in_ready; out_valid/out_state stay constant
// while out_valid=1 and out_ready=0. No new state is accepted until the result is taken.
module mix_cols_engine
    import aes_pkg::*;
#(
    parameter int NUM_COLS = aes_pkg::NUM_COLS,
    parameter int COL_W    = aes_pkg::COL_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_COLS*COL_W-1:0] in_state,
    input  logic                      in_inv,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_COLS*COL_W-1:0] out_state,
    output logic                      busy
);

    localparam int CNT_W = $clog2(NUM_COLS);
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(NUM_COLS - 1);

    eng_state_t                state;
    logic [CNT_W-1:0]          col_cnt;
    logic [NUM_COLS*COL_W-1:0] work;
    logic [NUM_COLS*COL_W-1:0] next_work;
    logic [COL_W-1:0]          cur_col;
    logic [COL_W-1:0]          mixed_col;
    logic                      inv_sel;

`ifdef MIX_COLS_INVERSE_EN
    logic inv_q;
    assign inv_sel = inv_q;
`else
    logic unused_in_inv;
    assign unused_in_inv = in_inv;
    assign inv_sel       = 1'b0;
`endif

    // Pick column col_cnt (column 0 sits in the MSBs) and splice the mixed value back.
    always_comb begin
        int idx;
        idx       = NUM_COLS - 1 - int'(col_cnt);
        cur_col   = work[idx*COL_W +: COL_W];
        next_work = work;
        next_work[idx*COL_W +: COL_W] = mixed_col;
    end

    mix_col u_mix_col (
        .col_in  (cur_col),
        .inv     (inv_sel),
        .col_out (mixed_col)
    );

    // Engine FSM with registered handshake outputs; reset discards any partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            col_cnt   <= '0;
            work      <= '0;
            out_state <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef MIX_COLS_INVERSE_EN
            inv_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work     <= in_state;
                        col_cnt  <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= BUSY;
`ifdef MIX_COLS_INVERSE_EN
                        inv_q    <= in_inv;
`endif
                    end
                end
                BUSY: begin
                    work    <= next_work;
                    col_cnt <= col_cnt + 1'b1;
                    if (col_cnt == LAST_COL) begin
                        out_state <= next_work;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mix_cols_engine.sv
// Bench for mix_cols_engine: directed vectors, backpressure, reset mid-operation,
// ignored input during processing, and randomized states against a GF(2^8) matrix model.
module tb_mix_cols_engine;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         in_inv;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    int pass_cnt = 0;
    int total    = 0;

    mix_cols_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_inv    (in_inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: GF(2^8) multiply by shift-and-add, then a circulant matrix per column.
    function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
        logic       hi;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1B;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
        logic [7:0]   cf [4];
        logic [7:0]   acc;
        logic [127:0] res;
        if (inv) begin
            cf[0] = 8'h0E; cf[1] = 8'h0B; cf[2] = 8'h0D; cf[3] = 8'h09;
        end else begin
            cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01;
        end
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gf_mul(cf[(k - r + 4) % 4], s[127 - 32*c - 8*k -: 8]);
                res[127 - 32*c - 8*r -: 8] = acc;
            end
        end
        return res;
    endfunction

    function automatic logic inv_effective(input logic inv);
`ifdef MIX_COLS_INVERSE_EN
        return inv;
`else
        return 1'b0 & inv;
`endif
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // One transaction, driven and checked cycle by cycle from the accept edge.
    // hold: cycles out_ready stays low once out_valid is up; garbage: junk on inputs while busy.
    task automatic run_txn(input logic [127:0] s, input logic inv, input logic [127:0] exp,
                           input int hold, input bit garbage);
        in_valid  = 1'b1;
        in_state  = s;
        in_inv    = inv;
        out_ready = (hold == 0);
        check("idle_in_ready", in_ready, 1);
        @(posedge clk);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (garbage) begin
                in_valid = 1'($urandom_range(0, 1));
                in_state = {$urandom, $urandom, $urandom, $urandom};
                in_inv   = 1'($urandom_range(0, 1));
            end else begin
                in_valid = 1'b0;
            end
            check($sformatf("busy_in_ready_c%0d", i), in_ready, 0);
            check($sformatf("busy_busy_c%0d", i), busy, 1);
            check($sformatf("busy_out_valid_c%0d", i), out_valid, 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("c5_out_valid", out_valid, 1);
        check("c5_out_state", out_state, exp);
        check("c5_in_ready", in_ready, 0);
        check("c5_busy", busy, 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_out_valid", out_valid, 1);
            check("hold_out_state", out_state, exp);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("post_in_ready", in_ready, 1);
        check("post_out_valid", out_valid, 0);
        check("post_busy", busy, 0);
    endtask

    localparam logic [127:0] V1_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V1_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V2_IN  = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    localparam logic [127:0] V2_OUT = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;

    initial begin
        logic [127:0] rs;
        logic         ri;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_state  = '0;
        in_inv    = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_state", out_state, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors.
        run_txn(V1_IN, 1'b0, V1_OUT, 0, 1'b0);
        run_txn(V2_IN, 1'b0, V2_OUT, 0, 1'b0);

        // Backpressure for 10 cycles.
        run_txn(V1_IN, 1'b0, V1_OUT, 10, 1'b0);

        // Reset during the second busy cycle.
        in_valid  = 1'b1;
        in_state  = V2_IN;
        in_inv    = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("midbusy_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_state", out_state, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_txn(V1_IN, 1'b0, V1_OUT, 0, 1'b0);

        // Junk on the input side while processing.
        run_txn(V1_IN, 1'b0, V1_OUT, 2, 1'b1);

        // Inverse request: undoes the forward mix when built in, otherwise plain forward.
`ifdef MIX_COLS_INVERSE_EN
        run_txn(V1_OUT, 1'b1, V1_IN, 0, 1'b0);
`else
        run_txn(V1_OUT, 1'b1, ref_mix(V1_OUT, 1'b0), 0, 1'b0);
`endif

        // Randomized states, inverse select, backpressure and junk input.
        for (int n = 0; n < 20; n++) begin
            rs = {$urandom, $urandom, $urandom, $urandom};
            ri = 1'($urandom_range(0, 1));
            run_txn(rs, ri, ref_mix(rs, inv_effective(ri)),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/mix_cols_engine.md
Name: mix_cols_engine

Overview:
- Forward AES MixColumns for the encryption datapath.
- Accepts a full 128-bit state and transforms one 32-bit column per clock through a shared combinational column mixer.
- Returns the mixed state over a valid/ready handshake.
- Sits between shift_rows and add_round_key in the round pipeline.

Parameters:
NUM_COLS, 4, columns per state (fixed at 4 for AES-128; used for counter sizing)
COL_W, 32, bits per column

Ports:
clk  input  1  system clock, all state updated on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_state is valid
in_ready  output  1  engine can accept a state
in_state  input  128  state; column c = bits [127-32c -: 32], row 0 = MSB byte of each column
in_inv  input  1  select InvMixColumns (used only with MIX_COLS_INVERSE_EN)
out_valid  output  1  out_state holds a completed result
out_ready  input  1  downstream accepts result
out_state  output  128  mixed state, same column/byte layout as in_state
busy  output  1  high while columns are being processed

Behaviour:
- Reset (async assert, sync-released by the system): state=IDLE, col_cnt=0, in_ready=1, out_valid=0, busy=0, out_state=0, working register=0.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, load in_state into the working register, latch in_inv, col_cnt=0, go to BUSY.
  - BUSY: in_ready=0, busy=1. Each cycle, replace working column col_cnt with mix_col(column) and increment col_cnt. On the cycle col_cnt==3 is written, go to DONE.
  - DONE: out_valid=1, out_state=working register, busy=0, in_ready=0. On out_ready, go to IDLE with out_valid=0.
- Latency: with the accept edge as edge 0, columns are written at edges 1..4. out_valid rises after edge 4 and the result is visible in cycle 5.
- Throughput: one state per 6 cycles minimum (accept, 4 busy, 1 handshake). No back-to-back overlap.
- out_state and out_valid are stable while out_valid=1 and out_ready=0 (backpressure holds indefinitely).
- in_valid during BUSY/DONE is ignored. The upstream must hold in_valid/in_state until in_ready.
- out_ready asserted while not in DONE has no effect.
- Arithmetic, GF(2^8) with poly 0x11B:
  - xtime(b) = (b<<1) ^ (b[7] ? 0x1B : 0), truncated to 8 bits.
  - Forward row r output = 2*a_r ^ 3*a_(r+1) ^ a_(r+2) ^ a_(r+3), indices mod 4.
- rst_n low mid-BUSY or mid-DONE: immediate return to reset values. The partial result is discarded and never presented.

Optional Feature:
- Macro MIX_COLS_INVERSE_EN.
- Defined:
  - The latched in_inv=1 selects InvMixColumns (coefficients 0e,0b,0d,09) for all four columns of that state.
  - in_inv is sampled only at accept. Changes during BUSY are ignored.
- Undefined:
  - in_inv is ignored and only forward logic is synthesized.
  - Port list is unchanged.

Decomposition:
- Shared package aes_pkg:
  - state_t (128-bit), col_t (32-bit), byte_t
  - AES_POLY=8'h1B
  - function xtime
  - engine state enum {IDLE, BUSY, DONE}
- Sub-module mix_col: purely combinational, col_t in, col_t out, inv select input tied 0 when the macro is undefined. Instantiated once; the engine muxes the column by col_cnt.

Test Plan:
1. Reset then single state in_state=db135345_f20a225c_01010101_c6c6c6c6, out_ready=1 -> out_valid rises in cycle 5 after accept, out_state=8e4da1bc_9fdc589d_01010101_c6c6c6c6, in_ready low cycles 1-5.
2. in_state=d4d4d4d5_2d26314c_00000000_ffffffff -> out_state=d5d5d7d6_4d7ebdf8_00000000_ffffffff.
3. Backpressure: scenario 1 with out_ready=0 for 10 cycles -> out_valid and out_state held constant, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
4. Reset mid-BUSY: assert rst_n=0 at busy cycle 2 -> out_valid=0, out_state=0, in_ready=1 immediately; a subsequent scenario-1 input still yields the correct result.
5. Ignored input: toggle in_valid with garbage during BUSY -> result unchanged from scenario 1.
6. (MIX_COLS_INVERSE_EN) in_inv=1, in_state=8e4da1bc_9fdc589d_01010101_c6c6c6c6 -> out_state=db135345_f20a225c_01010101_c6c6c6c6. Without the macro, same stimulus -> forward result of that state.
